// File: rtl/tone_sequence_player_pkg.sv
// Shared definitions for the tone sequence player: FSM states, rom_data field
// offsets, the rest encoding and a width helper for the tick prescaler.
// Pure declarations; no latency or flow control.
package tone_sequence_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // rom_data = {last, dur, half_period}
  localparam int HP_LSB = 0;

  function automatic int dur_lsb(input int per_w);
    return per_w;
  endfunction

  function automatic int last_bit(input int per_w, input int dur_w);
    return per_w + dur_w;
  endfunction

  // A half_period of zero marks the note as a rest.
  localparam int REST_HP = 0;

  // Prescaler width; kept at least one bit so TICK_CYCLES=1 still elaborates.
  function automatic int ps_width(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/tone_sequence_player_tone_divider.sv
// Square-wave generator: toggles tone every half_period cycles after clear drops.
// Latency: first toggle is visible half_period cycles after the first uncleared cycle.
// Backpressure: none; clear holds the counter and output at zero.
//
// Ports: clk, rst_n (sync, active low), clear (hold at zero),
//        half_period (0 = rest, output stays low), tone (registered output).
module tone_divider
  import tone_sequence_player_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [PER_W-1:0] half_period,
  output logic             tone
);

  localparam logic [PER_W-1:0] HP_ONE  = PER_W'(1);
  localparam logic [PER_W-1:0] HP_REST = PER_W'(REST_HP);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clear || (half_period == HP_REST)) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == (half_period - HP_ONE)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + HP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/tone_sequence_player.sv
// Plays a ROM-stored note sequence as a square wave; pulses seq_end on normal completion.
// Latency: start at cycle 0 -> FETCH 1, LOAD 2, first PLAY cycle 3; 2-cycle gap between notes.
// Backpressure: none; start is only honoured in IDLE, abort returns to IDLE from any state.
//
// Ports: clk, rst_n (sync, active low), start, abort,
//        rom_addr/rom_data (external ROM, one cycle read latency, data = {last, dur, half_period}),
//        tone_out (registered audio), busy (state != IDLE), seq_end (one cycle in DONE).
module tone_sequence_player
  import tone_sequence_player_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int PER_W       = 16,
  parameter int DUR_W       = 8,
  parameter int TICK_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DUR_W+PER_W:0]     rom_data,
  output logic                     tone_out,
  output logic                     busy,
  output logic                     seq_end
);

  localparam int PS_W     = ps_width(TICK_CYCLES);
  localparam int DUR_LSB  = dur_lsb(PER_W);
  localparam int LAST_BIT = last_bit(PER_W, DUR_W);

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICK_CYCLES - 1);
  localparam logic [PS_W-1:0]   PS_ONE    = PS_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [PER_W-1:0]  hp_q,    hp_d;
  logic [DUR_W-1:0]  dur_q,   dur_d;
  logic              last_q,  last_d;
  logic [PS_W-1:0]   pre_q,   pre_d;
  logic [DUR_W-1:0]  tick_q,  tick_d;

  logic [DUR_W-1:0]  tick_last;
  logic              div_clear;
  logic              div_tone;

  // dur=0 plays for one tick, same as dur=1.
  assign tick_last = (dur_q == '0) ? '0 : (dur_q - DUR_ONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hp_d    = hp_q;
    dur_d   = dur_q;
    last_d  = last_q;
    pre_d   = pre_q;
    tick_d  = tick_q;

    if (abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      pre_d   = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pre_d  = '0;
          tick_d = '0;
          if (start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
          end
        end
        ST_FETCH: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          hp_d    = rom_data[HP_LSB +: PER_W];
          dur_d   = rom_data[DUR_LSB +: DUR_W];
          last_d  = rom_data[LAST_BIT];
          pre_d   = '0;
          tick_d  = '0;
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (pre_q == PS_LAST) begin
            pre_d = '0;
            if (tick_q == tick_last) begin
              tick_d = '0;
              // The top address ends the sequence even without the last flag,
              // so the address never wraps back to 0 mid-sequence.
              if (last_q || (addr_q == ADDR_LAST)) begin
                state_d = ST_DONE;
              end else begin
                addr_d  = addr_q + ADDR_ONE;
                state_d = ST_FETCH;
              end
            end else begin
              tick_d = tick_q + DUR_ONE;
            end
          end else begin
            pre_d = pre_q + PS_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hp_q    <= '0;
      dur_q   <= '0;
      last_q  <= 1'b0;
      pre_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hp_q    <= hp_d;
      dur_q   <= dur_d;
      last_q  <= last_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  // Clear outside PLAY, and also on the cycle PLAY is being left, so that
  // tone_out is already 0 in the first FETCH/DONE/IDLE cycle after a note.
  assign div_clear = (state_q != ST_PLAY) || (state_d != ST_PLAY);

  tone_divider #(
    .PER_W (PER_W)
  ) u_tone_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (div_clear),
    .half_period (hp_q),
    .tone        (div_tone)
  );

  assign rom_addr = addr_q;
  assign tone_out = div_tone;
  assign busy     = (state_q != ST_IDLE);
  assign seq_end  = (state_q == ST_DONE);

endmodule

// File: tb/tb_tone_sequence_player.sv
// Bench for tone_sequence_player: per-cycle trace model plus directed and random runs.
// Latency: model expects FETCH/LOAD gap of two cycles before every note.
// Backpressure: none; start and abort are driven freely.
module tb_tone_sequence_player;

  localparam int ADDR_W = 3;
  localparam int PER_W  = 8;
  localparam int DUR_W  = 4;
  localparam int TICK   = 4;
  localparam int NOTES  = 1 << ADDR_W;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 abort;
  logic [ADDR_W-1:0]    rom_addr;
  logic [DUR_W+PER_W:0] rom_data;
  logic                 tone_out;
  logic                 busy;
  logic                 seq_end;

  logic [DUR_W+PER_W:0] rom_mem [NOTES];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  tone_sequence_player #(
    .ADDR_W      (ADDR_W),
    .PER_W       (PER_W),
    .DUR_W       (DUR_W),
    .TICK_CYCLES (TICK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .tone_out (tone_out),
    .busy     (busy),
    .seq_end  (seq_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, expv);
    end
  endtask

  function automatic logic [DUR_W+PER_W:0] note(input bit last, input int dur, input int hp);
    return {last, DUR_W'(dur), PER_W'(hp)};
  endfunction

  // ---------------- behavioural model ----------------
  // q[0] is the expected output of the current cycle; empty means IDLE.
  typedef struct {
    bit busy;
    bit se;
    bit tone;
    int addr;
  } exp_t;

  exp_t q[$];
  bit   model_on  = 0;
  bit   addr_zero = 1;
  bit   was_idle;

  function automatic void push(input bit b, input bit s, input bit t, input int a);
    exp_t e;
    e.busy = b; e.se = s; e.tone = t; e.addr = a;
    q.push_back(e);
  endfunction

  // Expand the whole sequence from ROM contents into a cycle-by-cycle trace.
  function automatic void build();
    for (int i = 0; i < NOTES; i++) begin
      logic [DUR_W+PER_W:0] w;
      int hp, dur, plen;
      bit last;
      w    = rom_mem[i];
      hp   = int'(w[PER_W-1:0]);
      dur  = int'(w[PER_W +: DUR_W]);
      last = w[PER_W+DUR_W];
      push(1, 0, 0, i);                         // FETCH
      push(1, 0, 0, i);                         // LOAD
      plen = ((dur == 0) ? 1 : dur) * TICK;
      for (int k = 0; k < plen; k++)
        push(1, 0, (hp == 0) ? 1'b0 : 1'(((k / hp) % 2)), i);
      if (last || i == NOTES - 1) begin
        push(1, 1, 0, i);                       // DONE
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n || abort) begin
      q.delete();
      addr_zero = 1;
    end else begin
      was_idle = (q.size() == 0);
      if (!was_idle) void'(q.pop_front());
      if (was_idle && start) begin
        build();
        addr_zero = 0;
      end
    end
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      exp_t e;
      e.busy = 0; e.se = 0; e.tone = 0; e.addr = 0;
      if (q.size() != 0) e = q[0];
      chk("busy", busy, e.busy);
      chk("seq_end", seq_end, e.se);
      chk("tone_out", tone_out, e.tone);
      if (e.busy) chk("rom_addr", rom_addr, e.addr);
      else if (addr_zero) chk("rom_addr_idle", rom_addr, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Start is high during cycle 0 and dropped in cycle 1.
  task automatic kick();
    start = 1;
    cyc   = 0;
    wait_to(1);
    start = 0;
  endtask

  initial begin
    rst_n = 0;
    start = 1;
    abort = 0;
    for (int i = 0; i < NOTES; i++) rom_mem[i] = '0;
    rom_mem[0] = note(1, 2, 3);

    // Reset held with start high: nothing may leave IDLE.
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_addr", rom_addr, 0);
    chk("reset_tone", tone_out, 0);

    // Release reset with start still high -> this is cycle 0 of a single note.
    rst_n = 1;
    cyc   = 0;
    wait_to(1);
    start = 0;
    chk("release_busy_c1", busy, 1);
    wait_to(5);  chk("single_tone_c5", tone_out, 0);
    wait_to(6);  chk("single_tone_c6", tone_out, 1);
    wait_to(9);  chk("single_tone_c9", tone_out, 0);
    wait_to(10); chk("single_se_c10", seq_end, 0);
    wait_to(11); chk("single_se_c11", seq_end, 1);
    wait_to(12); chk("single_busy_c12", busy, 0);

    // Three notes, the middle one a rest. DONE lands at cycle 19:
    // three 4-cycle notes starting at cycle 3 with two 2-cycle gaps.
    rom_mem[0] = note(0, 1, 2);
    rom_mem[1] = note(0, 1, 0);
    rom_mem[2] = note(1, 1, 1);
    wait_to(14);
    kick();
    wait_to(5);  chk("three_tone_c5", tone_out, 1);
    wait_to(7);  chk("three_addr_c7", rom_addr, 1);
    wait_to(9);  chk("three_rest_c9", tone_out, 0);
    wait_to(18); chk("three_se_c18", seq_end, 0);
    wait_to(19); chk("three_se_c19", seq_end, 1);
                 chk("three_addr_c19", rom_addr, 2);
    wait_to(20); chk("three_busy_c20", busy, 0);

    // Abort during PLAY, then a fresh start replays from address 0.
    rom_mem[0] = note(1, 2, 3);
    wait_to(23);
    kick();
    wait_to(6);  abort = 1;
    wait_to(7);  abort = 0;
    chk("abort_busy_c7", busy, 0);
    chk("abort_tone_c7", tone_out, 0);
    chk("abort_addr_c7", rom_addr, 0);
    wait_to(12); chk("abort_no_se", seq_end, 0);
    kick();
    wait_to(2);  chk("replay_addr_c2", rom_addr, 0);
    wait_to(11); chk("replay_se_c11", seq_end, 1);

    // start during PLAY is ignored; start+abort in IDLE stays IDLE.
    wait_to(13);
    kick();
    wait_to(5);  start = 1;
    wait_to(6);  start = 0;
    wait_to(11); chk("ign_se_c11", seq_end, 1);
    wait_to(13); chk("ign_busy_c13", busy, 0);
    start = 1; abort = 1;
    wait_to(14);
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    wait_to(15); chk("start_abort_busy2", busy, 0);

    // Eight notes, no last flag, dur=0 -> 4-cycle notes, DONE at cycle 49.
    for (int i = 0; i < NOTES; i++) rom_mem[i] = note(0, 0, i);
    wait_to(16);
    kick();
    wait_to(48); chk("eight_se_c48", seq_end, 0);
                 chk("eight_addr_c48", rom_addr, 7);
    wait_to(49); chk("eight_se_c49", seq_end, 1);
                 chk("eight_addr_c49", rom_addr, 7);
    wait_to(50); chk("eight_busy_c50", busy, 0);

    // Random sequences with random start/abort traffic; ROM changes only while idle.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NOTES; i++)
        rom_mem[i] = note(($urandom % 4) == 0, $urandom_range(0, 5), $urandom_range(0, 6));
      for (int c = 0; c < 400; c++) begin
        start = (($urandom % 8) == 0);
        abort = (($urandom % 150) == 0);
        @(negedge clk);
      end
      start = 0;
      abort = 1;
      @(negedge clk);
      abort = 0;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
